// File: rtl/tone_synth_pkg.sv
// Shared types and helpers for the tone_synth mixer: mix FSM states and amplitude scaling.
package tone_synth_pkg;

  typedef enum logic [1:0] {
    MIX_IDLE,
    MIX_SUM,
    MIX_DONE
  } mix_state_t;

  // The shift leaves log2(NUM_CH)+1 bits of headroom, so a full-scale sum of all channels cannot overflow.
  function automatic logic [63:0] amp_scale(input logic [63:0] env, input int sample_w,
                                            input int vol_w, input int num_ch);
    int shift;
    shift = sample_w - vol_w - $clog2(num_ch) - 1;
    return env << shift;
  endfunction

endpackage

// File: rtl/tone_synth_if.sv
// Channel-programming and sample-request bus of tone_synth; master is game logic / audio_driver side.
interface tone_synth_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 24,
  parameter int DIV_W    = 20,
  parameter int VOL_W    = 4
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                ch_wr;
  logic [SEL_W-1:0]    ch_sel;
  logic [DIV_W-1:0]    ch_div;
  logic [VOL_W-1:0]    ch_vol;
  logic                advance;
  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic                busy;
  logic [7:0]          drop_cnt;

  modport master (
    output ch_wr, ch_sel, ch_div, ch_vol, advance,
    input  sample, sample_valid, busy, drop_cnt
  );

  modport slave (
    input  ch_wr, ch_sel, ch_div, ch_vol, advance,
    output sample, sample_valid, busy, drop_cnt
  );
endinterface

// File: rtl/tone_synth_channel.sv
// One square-wave voice: half-period divider, phase bit and signed contribution.
// TONE_SYNTH_ENVELOPE_EN adds a per-channel decay prescaler that counts env down to 0.
module tone_channel
  import tone_synth_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SAMPLE_W    = 24,
  parameter int DIV_W       = 20,
  parameter int VOL_W       = 4,
  parameter int DECAY_TICKS = 250000
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       wr,
  input  logic [DIV_W-1:0]           div_in,
  input  logic [VOL_W-1:0]           vol_in,
  output logic signed [SAMPLE_W-1:0] contrib
);

  logic [DIV_W-1:0]           div_reg;
  logic [DIV_W-1:0]           cnt_reg;
  logic                       ph_reg;
  logic [VOL_W-1:0]           env_reg;
  logic signed [SAMPLE_W-1:0] amp;

`ifdef TONE_SYNTH_ENVELOPE_EN
  localparam int PRE_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  logic [PRE_W-1:0] pre_reg;
`endif

  // A write restarts the note and takes priority over a same-cycle phase toggle.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      div_reg <= '0;
      cnt_reg <= '0;
      ph_reg  <= 1'b0;
      env_reg <= '0;
`ifdef TONE_SYNTH_ENVELOPE_EN
      pre_reg <= '0;
`endif
    end else if (wr) begin
      div_reg <= div_in;
      cnt_reg <= '0;
      ph_reg  <= 1'b0;
      env_reg <= vol_in;
`ifdef TONE_SYNTH_ENVELOPE_EN
      pre_reg <= '0;
`endif
    end else begin
      if (div_reg == '0) begin
        cnt_reg <= '0;
        ph_reg  <= 1'b0;
      end else if (cnt_reg == div_reg - DIV_W'(1)) begin
        cnt_reg <= '0;
        ph_reg  <= ~ph_reg;
      end else begin
        cnt_reg <= cnt_reg + DIV_W'(1);
      end
`ifdef TONE_SYNTH_ENVELOPE_EN
      if (pre_reg == PRE_W'(DECAY_TICKS - 1)) begin
        pre_reg <= '0;
        if (env_reg != '0) env_reg <= env_reg - VOL_W'(1);
      end else begin
        pre_reg <= pre_reg + PRE_W'(1);
      end
`endif
    end
  end

  assign amp = SAMPLE_W'(amp_scale(64'(env_reg), SAMPLE_W, VOL_W, NUM_CH));

  always_comb begin
    contrib = '0;
    if (div_reg != '0 && env_reg != '0) contrib = ph_reg ? amp : -amp;
  end

endmodule

// File: rtl/tone_synth.sv
// Multi-channel square-wave tone generator: write decode, contribution snapshot, serial mix FSM.
// Optional decay envelope is enabled with TONE_SYNTH_ENVELOPE_EN.
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SAMPLE_W    = 24,
  parameter int DIV_W       = 20,
  parameter int VOL_W       = 4,
  parameter int DECAY_TICKS = 250000
) (
  input logic       Clk,
  input logic       Reset,
  tone_synth_if.slave bus
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic signed [SAMPLE_W-1:0] contrib  [NUM_CH];
  logic signed [SAMPLE_W-1:0] snap_reg [NUM_CH];
  logic [NUM_CH-1:0]          wr_sel;

  mix_state_t                 state_reg;
  logic signed [SAMPLE_W-1:0] acc_reg;
  logic [SEL_W-1:0]           idx_reg;
  logic [SAMPLE_W-1:0]        sample_reg;
  logic                       valid_reg;
  logic                       busy_reg;
  logic [7:0]                 drop_reg;

  // Out-of-range ch_sel matches no channel and is silently ignored.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wr_sel[gi] = bus.ch_wr && (bus.ch_sel == SEL_W'(gi));

      tone_channel #(
        .NUM_CH     (NUM_CH),
        .SAMPLE_W   (SAMPLE_W),
        .DIV_W      (DIV_W),
        .VOL_W      (VOL_W),
        .DECAY_TICKS(DECAY_TICKS)
      ) u_ch (
        .Clk    (Clk),
        .Reset  (Reset),
        .wr     (wr_sel[gi]),
        .div_in (bus.ch_div),
        .vol_in (bus.ch_vol),
        .contrib(contrib[gi])
      );
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg  <= MIX_IDLE;
      acc_reg    <= '0;
      idx_reg    <= '0;
      sample_reg <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      drop_reg   <= '0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        MIX_IDLE: begin
          if (bus.advance) begin
            snap_reg  <= contrib;
            acc_reg   <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= MIX_SUM;
          end
        end
        MIX_SUM: begin
          acc_reg <= acc_reg + snap_reg[idx_reg];
          if (idx_reg == SEL_W'(NUM_CH - 1)) state_reg <= MIX_DONE;
          else idx_reg <= idx_reg + SEL_W'(1);
        end
        MIX_DONE: begin
          sample_reg <= acc_reg;
          valid_reg  <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= MIX_IDLE;
        end
        default: state_reg <= MIX_IDLE;
      endcase
      if (bus.advance && state_reg != MIX_IDLE && drop_reg != 8'hFF)
        drop_reg <= drop_reg + 8'd1;
    end
  end

  assign bus.sample       = sample_reg;
  assign bus.sample_valid = valid_reg;
  assign bus.busy         = busy_reg;
  assign bus.drop_cnt     = drop_reg;

endmodule

// File: tb/tb_tone_synth.sv
// Self-checking bench for tone_synth: cycle-level behavioural model plus directed literal checks.
module tb_tone_synth;

  localparam int NCH = 4;
  localparam int SW  = 24;
  localparam int DW  = 20;
  localparam int VW  = 4;
  localparam int S   = 17;
  localparam int DT  = 10;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  tone_synth_if #(.NUM_CH(NCH), .SAMPLE_W(SW), .DIV_W(DW), .VOL_W(VW)) bus ();
  tone_synth_if #(.NUM_CH(3),   .SAMPLE_W(SW), .DIV_W(DW), .VOL_W(VW)) bus3 ();

  tone_synth #(.NUM_CH(NCH), .SAMPLE_W(SW), .DIV_W(DW), .VOL_W(VW), .DECAY_TICKS(DT)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );
  tone_synth #(.NUM_CH(3), .SAMPLE_W(SW), .DIV_W(DW), .VOL_W(VW), .DECAY_TICKS(DT)) dut3 (
    .Clk(Clk), .Reset(Reset), .bus(bus3)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s @%0t: got 0x%0h, required 0x%0h", name, $time, got, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_div [NCH];
  longint m_vol [NCH];
  longint m_w   [NCH];
  longint edge_n = 0;
  longint last_acc = 0;
  longint valid_edge = -1;
  bit     have_acc = 0;
  logic [SW-1:0] pend_sample = '0;
  logic [SW-1:0] exp_sample = '0;
  int     exp_drop = 0;

  // n = clock edges elapsed since the channel's note was (re)started.
  function automatic longint model_contrib(int i, longint n);
    longint env;
    longint amp;
    if (m_div[i] == 0) return 0;
    env = m_vol[i];
`ifdef TONE_SYNTH_ENVELOPE_EN
    env = env - n / DT;
    if (env < 0) env = 0;
`endif
    if (env == 0) return 0;
    amp = env * (longint'(1) << S);
    return (((n / m_div[i]) % 2) == 1) ? amp : -amp;
  endfunction

  always begin
    logic r, a, w, exp_valid, exp_busy;
    int sel;
    longint dv, vl, sum;
    @(posedge Clk);
    edge_n++;
    r = Reset; a = bus.advance; w = bus.ch_wr;
    sel = int'(bus.ch_sel); dv = longint'(bus.ch_div); vl = longint'(bus.ch_vol);
    if (!r) begin
      for (int i = 0; i < NCH; i++) begin
        m_div[i] = 0; m_vol[i] = 0; m_w[i] = edge_n;
      end
      have_acc = 0; valid_edge = -1; exp_sample = '0; exp_drop = 0;
    end else begin
      if (a) begin
        if (!have_acc || edge_n - last_acc >= NCH + 2) begin
          sum = 0;
          for (int i = 0; i < NCH; i++) sum += model_contrib(i, edge_n - 1 - m_w[i]);
          pend_sample = SW'(sum);
          valid_edge  = edge_n + NCH + 1;
          last_acc    = edge_n;
          have_acc    = 1;
        end else if (exp_drop < 255) begin
          exp_drop++;
        end
      end
      if (w && sel < NCH) begin
        m_div[sel] = dv; m_vol[sel] = vl; m_w[sel] = edge_n;
      end
      if (edge_n == valid_edge) exp_sample = pend_sample;
    end
    exp_valid = r && (edge_n == valid_edge);
    exp_busy  = r && have_acc && (edge_n >= last_acc) && (edge_n < last_acc + NCH + 1);
    #1;
    check("model_sample", 64'(bus.sample), 64'(exp_sample));
    check("model_valid",  64'(bus.sample_valid), 64'(exp_valid));
    check("model_busy",   64'(bus.busy), 64'(exp_busy));
    check("model_drop",   64'(bus.drop_cnt), 64'(exp_drop));
  end

  // ---------------- directed helpers ----------------
  task automatic wr(input bit which, input int sel, input int dv, input int vl);
    if (which) begin
      bus3.ch_wr = 1'b1; bus3.ch_sel = 2'(sel); bus3.ch_div = DW'(dv); bus3.ch_vol = VW'(vl);
    end else begin
      bus.ch_wr = 1'b1; bus.ch_sel = 2'(sel); bus.ch_div = DW'(dv); bus.ch_vol = VW'(vl);
    end
    @(negedge Clk);
    bus.ch_wr = 1'b0; bus3.ch_wr = 1'b0;
  endtask

  task automatic adv_expect(input bit which, input string name, input logic [SW-1:0] req);
    int lat;
    logic v;
    if (which) bus3.advance = 1'b1; else bus.advance = 1'b1;
    @(negedge Clk);
    bus.advance = 1'b0; bus3.advance = 1'b0;
    lat = 1;
    v = which ? bus3.sample_valid : bus.sample_valid;
    while (!v && lat < 20) begin
      @(negedge Clk);
      lat++;
      v = which ? bus3.sample_valid : bus.sample_valid;
    end
    check({name, "_latency"}, 64'(v ? lat : 99), 64'(which ? 5 : NCH + 2));
    check({name, "_sample"}, 64'(which ? bus3.sample : bus.sample), 64'(req));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nval;
    int js [4];
    logic [SW-1:0] env_exp [4];
    js = '{9, 10, 25, 30};
    env_exp = '{24'hFA0000, 24'hFC0000, 24'hFE0000, 24'h000000};

    Reset = 1'b0;
    bus.ch_wr = 0; bus.ch_sel = 0; bus.ch_div = 0; bus.ch_vol = 0; bus.advance = 0;
    bus3.ch_wr = 0; bus3.ch_sel = 0; bus3.ch_div = 0; bus3.ch_vol = 0; bus3.advance = 0;
    repeat (3) @(negedge Clk);
    check("rst_sample", 64'(bus.sample), 0);
    check("rst_valid",  64'(bus.sample_valid), 0);
    check("rst_busy",   64'(bus.busy), 0);
    check("rst_drop",   64'(bus.drop_cnt), 0);
    Reset = 1'b1;
    @(negedge Clk);

    adv_expect(0, "silent", 24'h000000);

    wr(0, 0, 4, 15); repeat (5) @(negedge Clk);
    adv_expect(0, "ch0_ph1", 24'h1E0000);
    wr(0, 0, 4, 15); @(negedge Clk);
    adv_expect(0, "ch0_ph0", 24'hE20000);

    for (int i = 0; i < NCH; i++) wr(0, i, 5, 15);
    repeat (6) @(negedge Clk);
    adv_expect(0, "all_ph1", 24'h780000);

    check("drop_before", 64'(bus.drop_cnt), 0);
    bus.advance = 1'b1; @(negedge Clk);
    bus.advance = 1'b0; @(negedge Clk);
    bus.advance = 1'b1; @(negedge Clk);
    bus.advance = 1'b0;
    nval = 0;
    repeat (12) begin
      @(negedge Clk);
      if (bus.sample_valid) nval++;
    end
    check("drop_one_valid", 64'(nval), 1);
    check("drop_one_cnt", 64'(bus.drop_cnt), 1);

    wr(1, 0, 1000, 5);
    wr(1, 3, 4, 15);
    adv_expect(1, "oor_write", 24'hF60000);

`ifdef TONE_SYNTH_ENVELOPE_EN
    for (int i = 1; i < NCH; i++) wr(0, i, 0, 0);
    for (int k = 0; k < 4; k++) begin
      wr(0, 0, 1000, 3);
      repeat (js[k]) @(negedge Clk);
      adv_expect(0, "env_step", env_exp[k]);
    end
`endif

    for (int c = 0; c < 1500; c++) begin
      bus.advance = ($urandom % 2) == 0;
      bus.ch_wr   = ($urandom % 5) == 0;
      bus.ch_sel  = 2'($urandom % 4);
      bus.ch_div  = (($urandom % 8) == 0) ? '0 : DW'($urandom_range(1, 12));
      bus.ch_vol  = VW'($urandom % 16);
      @(negedge Clk);
    end
    bus.advance = 1'b0; bus.ch_wr = 1'b0;
    repeat (8) @(negedge Clk);
    check("drop_saturated", 64'(bus.drop_cnt), 255);

    for (int c = 0; c < 2000; c++) begin
      Reset       = ($urandom % 150) != 0;
      bus.advance = ($urandom % 5) == 0;
      bus.ch_wr   = ($urandom % 7) == 0;
      bus.ch_sel  = 2'($urandom % 4);
      bus.ch_div  = (($urandom % 6) == 0) ? '0 : DW'($urandom_range(1, 300));
      bus.ch_vol  = VW'($urandom % 16);
      @(negedge Clk);
    end
    Reset = 1'b1; bus.advance = 1'b0; bus.ch_wr = 1'b0;
    repeat (10) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
